// File: rtl/fpall_pkg.sv
// Shared types for the FP arithmetic unit front end: opcode/format encodings
// and the request/response records carried between host, unit and FIFO.
package fpall_pkg;

  typedef enum logic [1:0] {
    FP_ADD  = 2'b00,
    FP_MUL  = 2'b01,
    FP_SQRT = 2'b10,
    FP_DIV  = 2'b11
  } fp_op_e;

  typedef enum logic {
    FMT_FP32 = 1'b0,
    FMT_FP16 = 1'b1
  } fp_fmt_e;

  // Tag width used by the request/response records.
  localparam int FPALL_TAG_W = 4;

  typedef struct packed {
    fp_op_e                 op;
    fp_fmt_e                fmt;
    logic [FPALL_TAG_W-1:0] tag;
    logic [31:0]            x;
    logic [31:0]            y;
  } fpall_req_t;

  typedef struct packed {
    logic [31:0]            data;
    logic [FPALL_TAG_W-1:0] tag;
    fp_fmt_e                fmt;
  } fpall_rsp_t;

endpackage

// File: rtl/fpall_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on rd_data while not empty
// and reads as zero when empty.
module fpall_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en)          wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/fpall_op_issuer.sv
// Host-side front end of the shared FP unit: credit-gated issue, fixed-latency tracking
// of in-flight ops, and in-order capture of results into a show-ahead response FIFO.
module fpall_op_issuer
  import fpall_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int TAG_W      = FPALL_TAG_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_fmt,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  output logic [1:0]       fp_opcode,
  output logic             fp_fmt,
  output logic [31:0]      fp_x,
  output logic [31:0]      fp_y,
  input  logic [31:0]      fp_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_fmt,
  output logic             busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fpall_req_t       req_c;
  fpall_rsp_t       cap_c;
  fpall_rsp_t       head_c;
  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  logic [CW-1:0]    credits_q, credits_d;
  fp_op_e           op_q, op_d;
  fp_fmt_e          fmt_q, fmt_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;

  logic [LATENCY:0] trk_vld_q, trk_vld_d;
  logic [TAG_W-1:0] trk_tag_q [LATENCY+1];
  logic [TAG_W-1:0] trk_tag_d [LATENCY+1];
  fp_fmt_e          trk_fmt_q [LATENCY+1];
  fp_fmt_e          trk_fmt_d [LATENCY+1];

  always_comb begin
    req_c.op  = fp_op_e'(req_op);
    req_c.fmt = fp_fmt_e'(req_fmt);
    req_c.tag = req_tag;
    req_c.x   = req_x;
    req_c.y   = req_y;
  end

  // Admission depends only on the credit register, never on this cycle's pop.
  assign req_ready = !rst && (credits_q < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (credits_q != '0);

  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    op_d  = op_q;
    fmt_d = fmt_q;
    x_d   = x_q;
    y_d   = y_q;
    if (accept) begin
      op_d  = req_c.op;
      fmt_d = req_c.fmt;
      x_d   = req_c.x;
      y_d   = req_c.y;
    end
  end

  // Stage i of the tracker lines up with the unit's stage i; bubbles shift through as valid=0.
  always_comb begin
    trk_vld_d[0] = accept;
    trk_tag_d[0] = req_c.tag;
    trk_fmt_d[0] = req_c.fmt;
    for (int i = 1; i <= LATENCY; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_tag_d[i] = trk_tag_q[i-1];
      trk_fmt_d[i] = trk_fmt_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= '0;
      op_q      <= FP_ADD;
      fmt_q     <= FMT_FP32;
      x_q       <= '0;
      y_q       <= '0;
      trk_vld_q <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        trk_tag_q[i] <= '0;
        trk_fmt_q[i] <= FMT_FP32;
      end
    end else begin
      credits_q <= credits_d;
      op_q      <= op_d;
      fmt_q     <= fmt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      trk_vld_q <= trk_vld_d;
      trk_tag_q <= trk_tag_d;
      trk_fmt_q <= trk_fmt_d;
    end
  end

  assign fp_opcode = op_q;
  assign fp_fmt    = fmt_q;
  assign fp_x      = x_q;
  assign fp_y      = y_q;

  always_comb begin
    cap_c.data = fp_r;
    cap_c.tag  = trk_tag_q[LATENCY];
    cap_c.fmt  = trk_fmt_q[LATENCY];
  end

  fpall_sync_fifo #(
    .WIDTH ($bits(fpall_rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (trk_vld_q[LATENCY]),
    .wr_data (cap_c),
    .rd_en   (pop),
    .rd_data (head_c),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head_c.data;
  assign rsp_tag   = head_c.tag;
  assign rsp_fmt   = head_c.fmt;

  // Every op in flight holds a credit, so a capture into a full FIFO is always paired with a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (trk_vld_q[LATENCY] && fifo_full) |-> pop);
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    credits_q <= CW'(FIFO_DEPTH));
  a_entries_hold_credit: assert property (@(posedge clk) disable iff (rst)
    !fifo_empty |-> busy);

endmodule

// File: tb/tb_fpall_op_issuer.sv
// Randomized and directed bench for fpall_op_issuer with a stub FP unit and a
// queue-based reference model of credits, latency and in-order responses.
module tb_fpall_op_issuer;

  localparam int LAT   = 2;
  localparam int DEPTH = 8;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic          req_fmt;
  logic [TW-1:0] req_tag;
  logic [31:0]   req_x;
  logic [31:0]   req_y;
  logic [1:0]    fp_opcode;
  logic          fp_fmt;
  logic [31:0]   fp_x;
  logic [31:0]   fp_y;
  logic [31:0]   fp_r;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_fmt;
  logic          busy;

  always #5 clk = ~clk;

  fpall_op_issuer #(
    .LATENCY    (LAT),
    .TAG_W      (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_fmt   (req_fmt),
    .req_tag   (req_tag),
    .req_x     (req_x),
    .req_y     (req_y),
    .fp_opcode (fp_opcode),
    .fp_fmt    (fp_fmt),
    .fp_x      (fp_x),
    .fp_y      (fp_y),
    .fp_r      (fp_r),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_fmt   (rsp_fmt),
    .busy      (busy)
  );

  // Stub FP unit: exact results for the directed vectors, a deterministic mix otherwise.
  function automatic logic [31:0] unit_fn(input logic [1:0] op, input logic fmt,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ye;
    if (op == 2'b00 && !fmt && x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
    if (op == 2'b01 && !fmt && x == 32'h4000_0000 && y == 32'h4040_0000) return 32'h40C0_0000;
    if (op == 2'b10 && !fmt && x == 32'h4080_0000)                        return 32'h4000_0000;
    if (op == 2'b11 && !fmt && x == 32'h40C0_0000 && y == 32'h4000_0000) return 32'h4040_0000;
    if (op == 2'b00 &&  fmt && x == 32'h0000_3C00 && y == 32'h0000_3C00) return 32'h0000_4000;
    ye = (op == 2'b10) ? 32'h0 : y;
    return (x ^ {ye[15:0], ye[31:16]}) + {28'h0, op, fmt, 1'b1} * 32'h0101_0101;
  endfunction

  logic [31:0] unit_pipe [LAT];
  always @(posedge clk) begin
    unit_pipe[0] <= unit_fn(fp_opcode, fp_fmt, fp_x, fp_y);
    for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
  end
  assign fp_r = unit_pipe[LAT-1];

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic          fmt;
    int            avail;
  } exp_t;

  exp_t          q[$];
  int            credits;
  logic [1:0]    m_op;
  logic          m_fmt;
  logic [31:0]   m_x;
  logic [31:0]   m_y;
  int            cyc;
  int            checks;
  int            errors;
  int            dut_acc;
  logic [TW-1:0] tag_ctr;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    credits = 0;
    m_op    = 2'b00;
    m_fmt   = 1'b0;
    m_x     = 32'h0;
    m_y     = 32'h0;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data",  64'(rsp_data),  64'(0));
    check("rst_rsp_tag",   64'(rsp_tag),   64'(0));
    check("rst_rsp_fmt",   64'(rsp_fmt),   64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_fp_opcode", 64'(fp_opcode), 64'(0));
    check("rst_fp_fmt",    64'(fp_fmt),    64'(0));
    check("rst_fp_x",      64'(fp_x),      64'(0));
    check("rst_fp_y",      64'(fp_y),      64'(0));
  endtask

  // One clock cycle: entered just after a rising edge, checks at the falling edge.
  task automatic cycle(input bit v, input logic [1:0] op, input logic fmt, input logic [TW-1:0] tag,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                       input bit rr);
    bit   exp_ready;
    bit   exp_valid;
    bit   acc;
    bit   pp;
    exp_t e;
    req_valid = v;
    req_op    = op;
    req_fmt   = fmt;
    req_tag   = tag;
    req_x     = x;
    req_y     = y;
    rsp_ready = rr;
    @(negedge clk);
    exp_ready = (credits < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    check("busy",      64'(busy),      64'(credits != 0));
    check("fp_opcode", 64'(fp_opcode), 64'(m_op));
    check("fp_fmt",    64'(fp_fmt),    64'(m_fmt));
    check("fp_x",      64'(fp_x),      64'(m_x));
    check("fp_y",      64'(fp_y),      64'(m_y));
    if (exp_valid) begin
      check("rsp_data", 64'(rsp_data), 64'(q[0].data));
      check("rsp_tag",  64'(rsp_tag),  64'(q[0].tag));
      check("rsp_fmt",  64'(rsp_fmt),  64'(q[0].fmt));
    end
    if (v && req_ready) dut_acc++;
    acc = v && exp_ready;
    pp  = exp_valid && rr;
    if (pp) begin
      void'(q.pop_front());
      credits--;
    end
    if (acc) begin
      e.data  = r;
      e.tag   = tag;
      e.fmt   = fmt;
      e.avail = cyc + LAT + 2;
      q.push_back(e);
      credits++;
      m_op    = op;
      m_fmt   = fmt;
      m_x     = x;
      m_y     = y;
      tag_ctr = tag_ctr + 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, '0, 32'h0, 32'h0, 32'h0, rr);
  endtask

  task automatic rand_cycle(input bit v, input bit rr);
    logic [1:0]  op;
    logic        fmt;
    logic [31:0] x;
    logic [31:0] y;
    op  = 2'($urandom_range(0, 3));
    fmt = 1'($urandom_range(0, 1));
    x   = $urandom;
    y   = $urandom;
    cycle(v, op, fmt, tag_ctr, x, y, unit_fn(op, fmt, x, y), rr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    dut_acc   = 0;
    tag_ctr   = '0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_fmt   = 1'b0;
    req_tag   = '0;
    req_x     = 32'h0;
    req_y     = 32'h0;
    rsp_ready = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single FP32 add, then idle until drained (busy falls the cycle after the pop).
    cycle(1'b1, 2'b00, 1'b0, 4'd3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    idle(6, 1'b1);

    // Back-to-back mul, sqrt, div with rsp_ready held high.
    cycle(1'b1, 2'b01, 1'b0, 4'd0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);
    cycle(1'b1, 2'b10, 1'b0, 4'd1, 32'h4080_0000, 32'h1234_5678, 32'h4000_0000, 1'b1);
    cycle(1'b1, 2'b11, 1'b0, 4'd2, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
    idle(6, 1'b1);

    // FP16 add passes through untouched.
    cycle(1'b1, 2'b00, 1'b1, 4'd5, 32'h0000_3C00, 32'h0000_3C00, 32'h0000_4000, 1'b1);
    idle(6, 1'b1);

    // Backpressure: exactly DEPTH accepts, one pop frees exactly one more.
    dut_acc = 0;
    for (int i = 0; i < 12; i++) rand_cycle(1'b1, 1'b0);
    check("bp_accepts", 64'(dut_acc), 64'(DEPTH));
    rand_cycle(1'b1, 1'b1);
    rand_cycle(1'b1, 1'b0);
    rand_cycle(1'b1, 1'b0);
    check("bp_accepts_after_pop", 64'(dut_acc), 64'(DEPTH + 1));
    idle(20, 1'b1);

    // Simultaneous accept and pop with DEPTH-1 credits in use.
    for (int i = 0; i < DEPTH - 1; i++) rand_cycle(1'b1, 1'b0);
    idle(LAT + 2, 1'b0);
    for (int i = 0; i < 20; i++) rand_cycle(1'b1, 1'b1);
    idle(DEPTH + LAT + 4, 1'b1);

    // Asynchronous reset with three ops in flight and two in the FIFO.
    for (int i = 0; i < 5; i++) rand_cycle(1'b1, 1'b0);
    req_valid = 1'b0;
    check("pre_rst_rsp_valid", 64'(rsp_valid), 64'(1));
    check("pre_rst_busy",      64'(busy),      64'(1));
    #2 rst = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    model_reset();
    cyc++;
    idle(8, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      rand_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    idle(DEPTH + LAT + 8, 1'b1);
    check("end_busy",      64'(busy),      64'(0));
    check("end_rsp_valid", 64'(rsp_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpall_op_issuer.md
Name: fpall_op_issuer

Overview:
Initiator-side front end for the shared FP arithmetic unit (add/mul/sqrt/div, FP32/FP16).
- Accepts tagged operation requests from a host over valid/ready.
- Registers them onto the unit's raw opcode/fmt/X/Y inputs.
- Tracks each operation through the unit's fixed pipeline latency.
- Captures R into an in-order response FIFO with valid/ready backpressure.
- Uses credit-based admission, because the FP unit cannot stall.

Parameters:
LATENCY, 2, register stages in the FP unit from X/Y/opcode/fmt inputs to R (0 allowed = combinational unit)
TAG_W, 4, width of the request/response tag
FIFO_DEPTH, 8, response FIFO entries; also the total credit count; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  host request valid
req_ready  out  1  block can accept a request
req_op  in  2  00 add, 01 mul, 10 sqrt, 11 div
req_fmt  in  1  0 FP32, 1 FP16
req_tag  in  TAG_W  host tag, returned unchanged
req_x  in  32  operand X
req_y  in  32  operand Y (ignored by unit for sqrt)
fp_opcode  out  2  to FP unit opcode
fp_fmt  out  1  to FP unit fmt
fp_x  out  32  to FP unit X
fp_y  out  32  to FP unit Y
fp_r  in  32  from FP unit R
rsp_valid  out  1  response available
rsp_ready  in  1  host takes response
rsp_data  out  32  result R
rsp_tag  out  TAG_W  tag of the originating request
rsp_fmt  out  1  fmt of the originating request
busy  out  1  any request accepted but not yet popped

Behaviour:
- Reset values while rst is high and after release:
  - fp_opcode, fp_fmt, fp_x, fp_y = 0.
  - rsp_valid = 0, rsp_data/rsp_tag/rsp_fmt = 0.
  - busy = 0.
  - Credit counter = 0, so req_ready = 1 in the first cycle after release.
  - req_ready is forced to 0 while rst is high.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready.
- req_ready = (credits_used < FIFO_DEPTH).
  - Decoded from registered state only.
  - No combinational path from rsp_ready or req_valid.
- Credits:
  - credits_used increments on accept and decrements on pop (rsp_valid && rsp_ready).
  - Simultaneous accept and pop leave it unchanged.
  - A credit freed by a pop becomes visible on req_ready the next cycle.
  - The FIFO can therefore never overflow.
- Issue stage:
  - On accept, fp_opcode/fp_fmt/fp_x/fp_y are registered from req_*.
  - Without an accept they hold their previous values; the unit result is then don't-care.
- Tracking pipeline: a valid bit plus {tag, fmt} shift alongside the unit through 1+LATENCY stages.
  - Stage 0 is set on accept; stage LATENCY marks that fp_r is valid this cycle.
  - Bubbles are carried as valid=0.
- Capture: when the final tracking stage is valid, {fp_r, tag, fmt} is written to the FIFO on that edge.
- Latency: with an accept in cycle 0 and an empty FIFO, rsp_valid first rises in cycle LATENCY+2.
- Throughput: 1 op/cycle sustained when rsp_ready=1 and FIFO_DEPTH >= LATENCY+3.
- Response FIFO:
  - Show-ahead; rsp_* reflect the head entry whenever rsp_valid=1.
  - Strict in-order; tags are never reordered.
  - Write and pop in the same cycle are both performed, including at full, because credits guarantee space.
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (credits_used != 0).
- Reset mid-operation:
  - All tracking valid bits, FIFO contents/pointers and credits are cleared immediately.
  - In-flight results are discarded.
  - Any fp_r arriving after reset is ignored because its tracking bit is gone.
- Data is passed through unaltered; no format checking or masking is applied for FP16.

Decomposition:
- Add to fpall_pkg:
  - fpall_req_t struct {fp_op_e op; fp_fmt_e fmt; tag; x; y}.
  - fpall_rsp_t struct {data; tag; fmt}.
  - Keep existing fp_op_e and fp_fmt_e.
- TAG_W default lives as a package localparam.
- One sub-module: fpall_sync_fifo.
  - Parameterised width/depth, show-ahead, async active-high reset.
  - Full/empty outputs are used only for assertions, since credits govern admission.

Test Plan:
- Single FP32 add, X=0x3F800000, Y=0x40000000, tag=3:
  - rsp_valid in cycle LATENCY+2.
  - rsp_data=0x40400000, rsp_tag=3, rsp_fmt=0; busy falls the cycle after pop.
- Back-to-back stream with rsp_ready=1:
  - Stream: mul 0x40000000*0x40400000 (tag 0), sqrt 0x40800000 (tag 1), div 0x40C00000/0x40000000 (tag 2).
  - Responses on consecutive cycles: 0x40C00000, 0x40000000, 0x40400000, tags 0,1,2.
- Backpressure with rsp_ready=0 and continuous req_valid:
  - Exactly 8 accepts, then req_ready=0.
  - Raise rsp_ready for one cycle: one pop, req_ready=1 on the next cycle, one more accept.
  - No data lost; tag order preserved.
- FP16 add, X=0x00003C00, Y=0x00003C00, fmt=1:
  - rsp_data[15:0]=0x4000, rsp_fmt=1.
- Reset asserted asynchronously mid-clock with 3 ops in flight and 2 in the FIFO:
  - Outputs go to reset values immediately.
  - After release no rsp_valid appears, and req_ready=1.
- Simultaneous accept and pop at credits_used=FIFO_DEPTH-1 for 20 cycles:
  - credits_used constant; req_ready stays 1.
  - Every response is matched by tag in order.
